serdes_stream_cipher: RTL and testbench
=======================================

Name: serdes_stream_cipher

Overview:
Parametrised multi-word successor to the single-byte serial XOR encryptor. Two serial plaintext streams (A, B) are deserialised into WIDTH-bit words. Each word is encrypted as A^B^K_i, where K_i is a rotating WIDTH-bit slice of a latched key, and the result is re-serialised MSB-first. A burst of num_words words runs per start. In/out handshake strobes are included so the block drops into the tt_um wrapper or a larger SerDes datapath.

Parameters:
WIDTH, 8, word width in bits (2..32)
KEY_WIDTH, 128, key width; must be an integer multiple of WIDTH; N_SLICES = KEY_WIDTH/WIDTH
CNT_W, 8, width of the num_words burst-length field

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  begin burst; sampled in IDLE only
key  input  KEY_WIDTH  key; latched on accepted start
num_words  input  CNT_W  words in burst; latched on accepted start
a_bit  input  1  serial stream A, MSB first
b_bit  input  1  serial stream B, MSB first
in_ready  output  1  high while the block samples a_bit/b_bit
cipher_out  output  1  serial ciphertext, MSB first
cipher_valid  output  1  cipher_out carries a valid bit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at burst end

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (rst_n sampled on clk rising edge).
- Reset values: cipher_out=0, cipher_valid=0, done=0, in_ready=0, busy=0. Internal state: IDLE; counters, shift registers, key latch and word index all 0.
- States: IDLE, SHIFT, ENCRYPT, OUTPUT, FINISH.
- IDLE, start=1:
  - latch key and num_words; word index i=0; clear A/B shift registers.
  - If num_words==0, go to FINISH; otherwise go to SHIFT.
- SHIFT:
  - in_ready=1 (decoded from state).
  - Each cycle: A<={A[WIDTH-2:0],a_bit}, B likewise; bit counter increments.
  - After exactly WIDTH samples, go to ENCRYPT.
- ENCRYPT (1 cycle, in_ready=0):
  - word <= A ^ B ^ key_l[WIDTH*(i mod N_SLICES) +: WIDTH].
  - Bit counter clears; go to OUTPUT.
- OUTPUT (WIDTH cycles):
  - Registered cipher_out <= word MSB, word shifts left; cipher_valid=1 on each of the WIDTH bits.
  - After the last bit, increment i:
    - if i+1 < num_words_l, go to SHIFT (new A/B cleared);
    - else go to FINISH.
- FINISH:
  - done=1 for exactly one cycle; cipher_valid=0; return to IDLE.
- Latency per word: start accepted at edge E0. First sample at E1. Word formed at E(WIDTH+1). First cipher bit visible after E(WIDTH+2). Word period = 2*WIDTH+1 cycles.
- The word index wraps modulo N_SLICES: slice 0 is reused after slice N_SLICES-1.
- start while busy is ignored. key and num_words changes after acceptance have no effect.
- start asserted in the same cycle done pulses: ignored; start is accepted the next cycle (IDLE).
- rst_n low mid-burst: all outputs return to reset values at the next edge; the burst is abandoned with no done pulse.
- cipher_out holds its last value when cipher_valid=0.

Optional Feature:
SERDES_CHAIN_EN
- Defined: CBC-style chaining. word_i = A^B^K_i^C_(i-1), where C_(i-1) is the previous ciphertext word of the same burst. C_(-1)=0, and the chain register clears on each accepted start and on reset.
- Undefined: no chain register; each word is independent (word_i = A^B^K_i).

Test Plan:
1. WIDTH=8, key[15:0]=16'h3C5A, num_words=1, A=0xF0, B=0x0F:
   - in_ready high for 8 cycles;
   - cipher_out bits 1,0,1,0,0,1,0,1 (0xA5) with cipher_valid high for 8 cycles;
   - done pulse 1 cycle later, busy low after.
2. num_words=2, word0 as scenario 1, word1 A=0x12 B=0x34:
   - outputs 0xA5 then 0x1A (K1=0x3C);
   - with SERDES_CHAIN_EN: 0xA5 then 0xBF.
3. KEY_WIDTH=16, WIDTH=8, key=16'h3C5A, num_words=3, A=B=0x00 each word -> outputs 0x5A, 0x3C, 0x5A (slice wrap).
4. num_words=0 with start -> no in_ready, no cipher_valid; done pulses exactly once, 2 cycles after start.
5. Assert start repeatedly mid-burst, then change key during SHIFT -> burst unaffected; outputs match the key latched at start.
6. Drop rst_n during OUTPUT of word 0 -> next edge: all outputs 0, busy=0, no done. A following fresh start runs normally with i=0 (and the chain register cleared when SERDES_CHAIN_EN is defined).

Source files
------------

// File: rtl/serdes_stream_cipher_if.sv
// Handshake and data bundle for serdes_stream_cipher: burst control, serial
// plaintext inputs and serial ciphertext outputs.
interface serdes_stream_cipher_if #(
    parameter int KEY_WIDTH = 128,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [KEY_WIDTH-1:0] key;
    logic [CNT_W-1:0]     num_words;
    logic                 a_bit;
    logic                 b_bit;
    logic                 in_ready;
    logic                 cipher_out;
    logic                 cipher_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, key, num_words, a_bit, b_bit,
        input  in_ready, cipher_out, cipher_valid, busy, done
    );

    modport slave (
        input  start, key, num_words, a_bit, b_bit,
        output in_ready, cipher_out, cipher_valid, busy, done
    );
endinterface

// File: rtl/serdes_stream_cipher.sv
// Serial two-stream XOR cipher: deserialise A/B words, XOR with a rotating key
// slice, reserialise MSB-first. Optional CBC chaining via SERDES_CHAIN_EN.
module serdes_stream_cipher #(
    parameter int WIDTH     = 8,
    parameter int KEY_WIDTH = 128,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serdes_stream_cipher_if.slave   bus
);
    localparam int             BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, ENCRYPT, OUTPUT, FINISH} state_t;

    state_t               state_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [WIDTH-1:0]     a_q, b_q, word_q, word_d;
    logic [KEY_WIDTH-1:0] key_q;
    logic [CNT_W-1:0]     rem_q;
    logic                 cipher_out_q, cipher_valid_q, done_q;
`ifdef SERDES_CHAIN_EN
    logic [WIDTH-1:0]     chain_q;
`endif

    // Key is rotated after every word so the active slice always sits in the low bits.
    function automatic logic [KEY_WIDTH-1:0] rotate_key(input logic [KEY_WIDTH-1:0] k);
        return (k >> WIDTH) | (k << (KEY_WIDTH - WIDTH));
    endfunction

    always_comb begin
        word_d = a_q ^ b_q ^ key_q[WIDTH-1:0];
`ifdef SERDES_CHAIN_EN
        word_d = word_d ^ chain_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            a_q            <= '0;
            b_q            <= '0;
            word_q         <= '0;
            key_q          <= '0;
            rem_q          <= '0;
            cipher_out_q   <= 1'b0;
            cipher_valid_q <= 1'b0;
            done_q         <= 1'b0;
`ifdef SERDES_CHAIN_EN
            chain_q        <= '0;
`endif
        end else begin
            done_q         <= 1'b0;
            cipher_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // done_q high means FINISH just left; a start in that cycle is dropped.
                    if (bus.start && !done_q) begin
                        key_q     <= bus.key;
                        rem_q     <= bus.num_words;
                        a_q       <= '0;
                        b_q       <= '0;
                        bit_cnt_q <= '0;
`ifdef SERDES_CHAIN_EN
                        chain_q   <= '0;
`endif
                        state_q   <= (bus.num_words == '0) ? FINISH : SHIFT;
                    end
                end
                SHIFT: begin
                    a_q       <= {a_q[WIDTH-2:0], bus.a_bit};
                    b_q       <= {b_q[WIDTH-2:0], bus.b_bit};
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        state_q   <= ENCRYPT;
                    end
                end
                ENCRYPT: begin
                    word_q    <= word_d;
                    key_q     <= rotate_key(key_q);
`ifdef SERDES_CHAIN_EN
                    chain_q   <= word_d;
`endif
                    bit_cnt_q <= '0;
                    state_q   <= OUTPUT;
                end
                OUTPUT: begin
                    cipher_out_q   <= word_q[WIDTH-1];
                    cipher_valid_q <= 1'b1;
                    word_q         <= word_q << 1;
                    bit_cnt_q      <= bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        rem_q     <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= FINISH;
                        end else begin
                            a_q     <= '0;
                            b_q     <= '0;
                            state_q <= SHIFT;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == SHIFT);
    assign bus.busy         = (state_q != IDLE);
    assign bus.cipher_out   = cipher_out_q;
    assign bus.cipher_valid = cipher_valid_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_serdes_stream_cipher.sv
// Randomised bench for serdes_stream_cipher with a word-level reference model
// (slice = key >> WIDTH*(i mod N_SLICES), optional chaining on SERDES_CHAIN_EN).
module tb_serdes_stream_cipher;
    localparam int W  = 8;
    localparam int KW = 16;
    localparam int CW = 8;
    localparam int NS = KW / W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serdes_stream_cipher_if #(.KEY_WIDTH(KW), .CNT_W(CW)) bus();

    serdes_stream_cipher #(.WIDTH(W), .KEY_WIDTH(KW), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] a_w [16];
    logic [W-1:0] b_w [16];
    logic [W-1:0] exp_w [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: every word is A^B^slice(i mod NS) (^ previous ciphertext when chained).
    task automatic build_model(input logic [KW-1:0] k, input int nw);
        logic [W-1:0] prev;
        prev = '0;
        for (int j = 0; j < nw; j++) begin
            exp_w[j] = a_w[j] ^ b_w[j] ^ W'(k >> (W * (j % NS)));
`ifdef SERDES_CHAIN_EN
            exp_w[j] = exp_w[j] ^ prev;
`endif
            prev = exp_w[j];
        end
    endtask

    task automatic run_burst(input logic [KW-1:0] k, input int nw, input bit disturb);
        int in_cnt, out_cnt, done_cnt, done_at, first_vld, budget, j, bi, idx;
        logic [W-1:0] sh;
        in_cnt = 0; out_cnt = 0; done_cnt = 0; done_at = -1; first_vld = -1;
        sh = '0;
        budget = nw * (2 * W + 1) + 8;
        build_model(k, nw);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.key       = k;
        bus.num_words = CW'(nw);
        @(negedge clk);
        for (int c = 1; c <= budget && done_at < 0; c++) begin
            if (bus.cipher_valid) begin
                if (first_vld < 0) first_vld = c;
                sh = {sh[W-2:0], bus.cipher_out};
                out_cnt++;
                if (out_cnt % W == 0) begin
                    idx = out_cnt / W - 1;
                    if (idx > 15) idx = 15;
                    check_val($sformatf("word%0d", idx), sh, exp_w[idx]);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_at = c;
            end
            bus.start = 1'b0;
            if (disturb) begin
                bus.start     = 1'($urandom);
                bus.key       = KW'($urandom);
                bus.num_words = CW'($urandom);
            end
            if (bus.in_ready) begin
                j  = in_cnt / W;
                bi = W - 1 - (in_cnt % W);
                if (j > 15) j = 15;
                bus.a_bit = a_w[j][bi];
                bus.b_bit = b_w[j][bi];
                in_cnt++;
            end else begin
                bus.a_bit = 1'($urandom);
                bus.b_bit = 1'($urandom);
            end
            // A start raised while done is visible must be dropped.
            if (done_at >= 0 && disturb) bus.start = 1'b1;
            @(negedge clk);
        end
        check_val("done_cycle", 64'(done_at), 64'(nw * (2 * W + 1) + 2));
        check_val("in_ready_cycles", 64'(in_cnt), 64'(nw * W));
        check_val("valid_cycles", 64'(out_cnt), 64'(nw * W));
        if (nw > 0) check_val("first_valid_cycle", 64'(first_vld), 64'(W + 3));
        check_val("busy_after_done", 64'(bus.busy), 64'(0));
        check_val("done_width", 64'(bus.done), 64'(0));
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [KW-1:0] rk;
        int rn, seen, dn;
        bus.start = 1'b0; bus.key = '0; bus.num_words = '0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cipher_out", 64'(bus.cipher_out), 64'(0));
        check_val("rst_cipher_valid", 64'(bus.cipher_valid), 64'(0));
        check_val("rst_done", 64'(bus.done), 64'(0));
        check_val("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check_val("rst_busy", 64'(bus.busy), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, two words, slice wrap, empty burst, disturbed burst.
        a_w[0] = 8'hF0; b_w[0] = 8'h0F;
        run_burst(16'h3C5A, 1, 1'b0);
        a_w[1] = 8'h12; b_w[1] = 8'h34;
        run_burst(16'h3C5A, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin a_w[i] = '0; b_w[i] = '0; end
        run_burst(16'h3C5A, 3, 1'b0);
        run_burst(16'h3C5A, 0, 1'b0);
        a_w[0] = 8'hF0; b_w[0] = 8'h0F; a_w[1] = 8'h12; b_w[1] = 8'h34;
        run_burst(16'h3C5A, 2, 1'b1);

        // Reset while the first cipher bit (a 1) is on the line.
        a_w[0] = 8'h80; b_w[0] = 8'h00; a_w[1] = 8'h55; b_w[1] = 8'hAA;
        @(negedge clk);
        bus.start = 1'b1; bus.key = '0; bus.num_words = CW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if (bus.cipher_valid) begin
                seen = 1;
            end else begin
                if (bus.in_ready) begin bus.a_bit = a_w[0][W-1-(c%W)]; bus.b_bit = 1'b0; end
                @(negedge clk);
            end
        end
        check_val("rst_reach_output", 64'(seen), 64'(1));
        check_val("rst_pre_bit", 64'(bus.cipher_out), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_cipher_out", 64'(bus.cipher_out), 64'(0));
        check_val("midrst_cipher_valid", 64'(bus.cipher_valid), 64'(0));
        check_val("midrst_done", 64'(bus.done), 64'(0));
        check_val("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        check_val("midrst_busy", 64'(bus.busy), 64'(0));
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        check_val("no_done_after_rst", 64'(dn), 64'(0));
        run_burst(16'hA5C3, 2, 1'b0);

        // Random bursts, some with start/key/num_words noise while busy.
        for (int t = 0; t < 20; t++) begin
            rk = KW'($urandom);
            rn = int'($urandom_range(0, 5));
            for (int i = 0; i < 6; i++) begin
                a_w[i] = W'($urandom);
                b_w[i] = W'($urandom);
            end
            run_burst(rk, rn, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
